// File: rtl/io_port_peripheral.sv
// Board-side partner of the Processor I/O port: an RX byte FIFO feeding INPUT_PORT_PINS with an
// INTR_IN pulse per byte, and a TX byte FIFO draining OUT writes to an external valid/ready sink.
module io_port_peripheral #(
   parameter int DEPTH       = 4,
   parameter int INTR_CYCLES = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ext_rx_data,
   input  logic       ext_rx_valid,
   output logic       ext_rx_ready,
   output logic [7:0] input_port_pins,
   input  logic       in_rd,
   output logic       intr_in,
   input  logic [7:0] output_port_pins,
   input  logic       out_wr,
   output logic [7:0] ext_tx_data,
   output logic       ext_tx_valid,
   input  logic       ext_tx_ready,
   output logic       tx_drop
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int PW = $clog2(INTR_CYCLES + 1);
   localparam logic [CW-1:0] FULL_C      = CW'(DEPTH);
   localparam logic [PW-1:0] PULSE_LEN_C = PW'(INTR_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PULSE   = 2'd1,
      ST_WAIT_RD = 2'd2
   } state_t;

   logic [7:0]    rx_mem_r [DEPTH];
   logic [AW-1:0] rx_wp_r;
   logic [AW-1:0] rx_rp_r;
   logic [CW-1:0] rx_count_r;
   logic [7:0]    tx_mem_r [DEPTH];
   logic [AW-1:0] tx_wp_r;
   logic [AW-1:0] tx_rp_r;
   logic [CW-1:0] tx_count_r;
   logic          tx_drop_r;

   state_t        state_r;
   logic [PW-1:0] pulse_cnt_r;
   logic          served_r;
   logic          intr_r;

   logic rx_has_data_s;
   logic rx_push_s;
   logic rx_pop_s;
   logic tx_has_data_s;
   logic tx_push_s;
   logic tx_pop_s;
   logic tx_reject_s;

   // Handshake decisions, all derived from registered counts so ready has no input path.
   always_comb begin
      rx_has_data_s = (rx_count_r != {CW{1'b0}});
      rx_push_s     = ext_rx_valid & (rx_count_r != FULL_C);
      rx_pop_s      = in_rd & rx_has_data_s;
      tx_has_data_s = (tx_count_r != {CW{1'b0}});
      tx_pop_s      = tx_has_data_s & ext_tx_ready;
      tx_push_s     = out_wr & ((tx_count_r != FULL_C) | tx_pop_s);
      tx_reject_s   = out_wr & ~tx_push_s;
   end

   // Head bytes are gated by the count so stale storage never reaches the pins.
   always_comb begin
      if (rx_has_data_s) begin
         input_port_pins = rx_mem_r[rx_rp_r];
      end else begin
         input_port_pins = 8'h00;
      end
      if (tx_has_data_s) begin
         ext_tx_data = tx_mem_r[tx_rp_r];
      end else begin
         ext_tx_data = 8'h00;
      end
   end

   assign ext_rx_ready = (rx_count_r != FULL_C);
   assign ext_tx_valid = tx_has_data_s;
   assign intr_in      = intr_r;
   assign tx_drop      = tx_drop_r;

   // FIFO storage writes; contents need no reset because reads are gated by the counts.
   always_ff @(posedge clk) begin
      if (rx_push_s) begin
         rx_mem_r[rx_wp_r] <= ext_rx_data;
      end
      if (tx_push_s) begin
         tx_mem_r[tx_wp_r] <= output_port_pins;
      end
   end

   // RX pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_wp_r    <= {AW{1'b0}};
         rx_rp_r    <= {AW{1'b0}};
         rx_count_r <= {CW{1'b0}};
      end else begin
         if (rx_push_s) begin
            rx_wp_r <= rx_wp_r + AW'(1);
         end
         if (rx_pop_s) begin
            rx_rp_r <= rx_rp_r + AW'(1);
         end
         case ({rx_push_s, rx_pop_s})
            2'b10:   rx_count_r <= rx_count_r + CW'(1);
            2'b01:   rx_count_r <= rx_count_r - CW'(1);
            default: rx_count_r <= rx_count_r;
         endcase
      end
   end

   // TX pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_wp_r    <= {AW{1'b0}};
         tx_rp_r    <= {AW{1'b0}};
         tx_count_r <= {CW{1'b0}};
         tx_drop_r  <= 1'b0;
      end else begin
         if (tx_push_s) begin
            tx_wp_r <= tx_wp_r + AW'(1);
         end
         if (tx_pop_s) begin
            tx_rp_r <= tx_rp_r + AW'(1);
         end
         case ({tx_push_s, tx_pop_s})
            2'b10:   tx_count_r <= tx_count_r + CW'(1);
            2'b01:   tx_count_r <= tx_count_r - CW'(1);
            default: tx_count_r <= tx_count_r;
         endcase
         tx_drop_r <= tx_drop_r | tx_reject_s;
      end
   end

   // Interrupt sequencer: one fixed-width pulse per byte, then wait for the byte to be read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         pulse_cnt_r <= {PW{1'b0}};
         served_r    <= 1'b0;
         intr_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (rx_has_data_s) begin
                  state_r     <= ST_PULSE;
                  pulse_cnt_r <= PULSE_LEN_C;
                  served_r    <= 1'b0;
                  intr_r      <= 1'b1;
               end
            end
            ST_PULSE: begin
               if (pulse_cnt_r == PW'(1)) begin
                  pulse_cnt_r <= {PW{1'b0}};
                  served_r    <= 1'b0;
                  intr_r      <= 1'b0;
                  // A read during the pulse already consumed the byte, so skip the wait.
                  state_r     <= (served_r | rx_pop_s) ? ST_IDLE : ST_WAIT_RD;
               end else begin
                  pulse_cnt_r <= pulse_cnt_r - PW'(1);
                  served_r    <= served_r | rx_pop_s;
                  intr_r      <= 1'b1;
               end
            end
            ST_WAIT_RD: begin
               intr_r <= 1'b0;
               if (rx_pop_s) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               pulse_cnt_r <= {PW{1'b0}};
               served_r    <= 1'b0;
               intr_r      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_io_port_peripheral.sv
// Randomized and directed bench for io_port_peripheral against a queue-based reference model.
module tb_io_port_peripheral;

   localparam int DEPTH = 4;
   localparam int INTR  = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] ext_rx_data = 8'h00;
   logic       ext_rx_valid = 1'b0;
   logic       ext_rx_ready;
   logic [7:0] input_port_pins;
   logic       in_rd = 1'b0;
   logic       intr_in;
   logic [7:0] output_port_pins = 8'h00;
   logic       out_wr = 1'b0;
   logic [7:0] ext_tx_data;
   logic       ext_tx_valid;
   logic       ext_tx_ready = 1'b0;
   logic       tx_drop;

   int n_checks = 0;
   int n_pass   = 0;

   io_port_peripheral #(.DEPTH(DEPTH), .INTR_CYCLES(INTR)) dut (
      .clk(clk), .rst_n(rst_n),
      .ext_rx_data(ext_rx_data), .ext_rx_valid(ext_rx_valid), .ext_rx_ready(ext_rx_ready),
      .input_port_pins(input_port_pins), .in_rd(in_rd), .intr_in(intr_in),
      .output_port_pins(output_port_pins), .out_wr(out_wr),
      .ext_tx_data(ext_tx_data), .ext_tx_valid(ext_tx_valid), .ext_tx_ready(ext_tx_ready),
      .tx_drop(tx_drop)
   );

   always #5 clk = ~clk;

   // Reference model: byte queues plus a small description of the interrupt protocol.
   logic [7:0] rxq[$];
   logic [7:0] txq[$];
   bit         drop_m;
   int         pulse_left_m;
   bit         await_rd_m;
   bit         read_in_pulse_m;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      rxq.delete();
      txq.delete();
      drop_m = 1'b0;
      pulse_left_m = 0;
      await_rd_m = 1'b0;
      read_in_pulse_m = 1'b0;
   endfunction

   function automatic void model_step(bit rv, logic [7:0] rdat, bit rd, bit wr, logic [7:0] wdat, bit txr);
      bit had     = rxq.size() > 0;
      bit rd_hit  = rd && had;
      bit rx_take = rv && (rxq.size() < DEPTH);
      bit tx_pop  = (txq.size() > 0) && txr;
      bit tx_take = wr && ((txq.size() < DEPTH) || tx_pop);
      if (pulse_left_m > 0) begin
         read_in_pulse_m = read_in_pulse_m | rd_hit;
         pulse_left_m--;
         if (pulse_left_m == 0) await_rd_m = !read_in_pulse_m;
      end else if (await_rd_m) begin
         if (rd_hit) await_rd_m = 1'b0;
      end else if (had) begin
         pulse_left_m = INTR;
         read_in_pulse_m = 1'b0;
      end
      if (rd_hit) void'(rxq.pop_front());
      if (rx_take) rxq.push_back(rdat);
      if (tx_pop) void'(txq.pop_front());
      if (tx_take) txq.push_back(wdat);
      if (wr && !tx_take) drop_m = 1'b1;
   endfunction

   task automatic check_outputs();
      chk("rx_ready", {7'd0, ext_rx_ready}, {7'd0, rxq.size() < DEPTH});
      chk("in_pins", input_port_pins, (rxq.size() > 0) ? rxq[0] : 8'h00);
      chk("intr_in", {7'd0, intr_in}, {7'd0, pulse_left_m > 0});
      chk("tx_valid", {7'd0, ext_tx_valid}, {7'd0, txq.size() > 0});
      chk("tx_data", ext_tx_data, (txq.size() > 0) ? txq[0] : 8'h00);
      chk("tx_drop", {7'd0, tx_drop}, {7'd0, drop_m});
   endtask

   // One clock: drive inputs after a falling edge, step the model, check at the next falling edge.
   task automatic cycle(input bit rv, input logic [7:0] rdat, input bit rd,
                        input bit wr, input logic [7:0] wdat, input bit txr);
      ext_rx_valid     = rv;
      ext_rx_data      = rdat;
      in_rd            = rd;
      out_wr           = wr;
      output_port_pins = wdat;
      ext_tx_ready     = txr;
      model_step(rv, rdat, rd, wr, wdat, txr);
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ext_rx_valid = 1'b0; in_rd = 1'b0; out_wr = 1'b0; ext_tx_ready = 1'b0;
      model_reset();
      #1;
      chk("rst_intr", {7'd0, intr_in}, 8'h00);
      chk("rst_txv", {7'd0, ext_tx_valid}, 8'h00);
      chk("rst_rdy", {7'd0, ext_rx_ready}, 8'h01);
      chk("rst_pins", input_port_pins, 8'h00);
      chk("rst_txd", ext_tx_data, 8'h00);
      chk("rst_drop", {7'd0, tx_drop}, 8'h00);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] tx_bytes [4];
      tx_bytes[0] = 8'h18; tx_bytes[1] = 8'hB7; tx_bytes[2] = 8'h4A; tx_bytes[3] = 8'h50;
      @(negedge clk);
      do_reset();
      idle(2);

      // Single byte, read while waiting after its pulse.
      cycle(1'b1, 8'h42, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("pins_42", input_port_pins, 8'h42);
      chk("intr_lag", {7'd0, intr_in}, 8'h00);
      idle(6);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
      chk("pins_after_rd", input_port_pins, 8'h00);
      idle(6);

      // Fill RX, hold a fifth byte, read each byte after its pulse.
      cycle(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0);
      cycle(1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0);
      cycle(1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0);
      cycle(1'b1, 8'h44, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("rx_full", {7'd0, ext_rx_ready}, 8'h00);
      for (int i = 0; i < 6; i++) cycle(1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0);
      cycle(1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0);
      cycle(1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0);
      for (int k = 0; k < 4; k++) begin
         idle(6);
         cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
      end
      idle(6);
      chk("rx_empty", input_port_pins, 8'h00);

      // Read during the second pulse cycle: no wait state, no second pulse.
      cycle(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0);
      idle(2);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
      idle(6);

      // TX fill, overflow drop, drain.
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, tx_bytes[i], 1'b0);
      chk("tx_head", ext_tx_data, 8'h18);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0);
      chk("tx_drop_set", {7'd0, tx_drop}, 8'h01);
      for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);

      // Write into a full TX FIFO while it pops.
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, tx_bytes[i], 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 1'b1);
      chk("tx_nodrop", {7'd0, tx_drop}, 8'h00);
      chk("tx_head2", ext_tx_data, 8'hB7);
      for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);

      // Asynchronous reset in the middle of a pulse with both FIFOs occupied.
      cycle(1'b1, 8'hC1, 1'b0, 1'b1, 8'hD1, 1'b0);
      cycle(1'b1, 8'hC2, 1'b0, 1'b1, 8'hD2, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'hD3, 1'b0);
      chk("pre_rst_intr", {7'd0, intr_in}, 8'h01);
      #2;
      do_reset();
      idle(8);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         cycle(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 9) < 4), 8'($urandom), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
